// File: rtl/lcd_nibble_writer.sv
// HD44780-style 4-bit bus writer: splits each byte into high/low nibble transfers
// with setup/enable/hold timing, then waits out the controller execution time.
module lcd_nibble_writer #(
  parameter int SETUP_CYCLES     = 5,
  parameter int PULSE_CYCLES     = 25,
  parameter int HOLD_CYCLES      = 2,
  parameter int WAIT_CYCLES      = 4000,
  parameter int LONG_WAIT_CYCLES = 164000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  input  logic       in_nibble_only,
  output logic       rs,
  output logic       e,
  output logic [7:4] d,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, SETUP_HI, PULSE_HI, HOLD_HI, SETUP_LO, PULSE_LO, HOLD_LO, WAIT
  } state_t;

  localparam logic [19:0] S_LD  = 20'(SETUP_CYCLES - 1);
  localparam logic [19:0] P_LD  = 20'(PULSE_CYCLES - 1);
  localparam logic [19:0] H_LD  = 20'(HOLD_CYCLES - 1);
  localparam logic [19:0] W_LD  = 20'(WAIT_CYCLES - 1);
  localparam logic [19:0] LW_LD = 20'(LONG_WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        rs_lat_q, rs_lat_d;
  logic        nib_q, nib_d;
  logic        rs_q, rs_d;
  logic        e_q, e_d;
  logic [3:0]  d_q, d_d;
  logic        done_q, done_d;
  logic        accept, last, long_cmd;

  assign in_ready = (state_q == IDLE) & ~reset;
  assign accept   = in_valid & in_ready;
  assign last     = (cnt_q == 20'd0);
  // Clear display (0x01) and return home (0x02/0x03) need the long execution time
  assign long_cmd = ~rs_lat_q & ~nib_q & (data_q[7:2] == 6'd0) & (data_q[1:0] != 2'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = last ? cnt_q : cnt_q - 20'd1;
    data_d   = data_q;
    rs_lat_d = rs_lat_q;
    nib_d    = nib_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        data_d   = in_data;
        rs_lat_d = in_rs;
        nib_d    = in_nibble_only;
        state_d  = SETUP_HI;
        cnt_d    = S_LD;
      end
      SETUP_HI: if (last) begin state_d = PULSE_HI; cnt_d = P_LD; end
      PULSE_HI: if (last) begin state_d = HOLD_HI;  cnt_d = H_LD; end
      HOLD_HI: if (last) begin
        if (nib_q) begin state_d = WAIT;     cnt_d = W_LD; end
        else       begin state_d = SETUP_LO; cnt_d = S_LD; end
      end
      SETUP_LO: if (last) begin state_d = PULSE_LO; cnt_d = P_LD; end
      PULSE_LO: if (last) begin state_d = HOLD_LO;  cnt_d = H_LD; end
      HOLD_LO: if (last) begin
        state_d = WAIT;
        cnt_d   = long_cmd ? LW_LD : W_LD;
      end
      WAIT: if (last) begin state_d = IDLE; done_d = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  // Pin drive is registered from the next state so the bus is glitch-free
  always_comb begin
    rs_d = rs_q;
    d_d  = d_q;
    e_d  = (state_d == PULSE_HI) || (state_d == PULSE_LO);
    unique case (state_d)
      SETUP_HI, PULSE_HI, HOLD_HI: begin d_d = data_d[7:4]; rs_d = rs_lat_d; end
      SETUP_LO, PULSE_LO, HOLD_LO: begin d_d = data_d[3:0]; rs_d = rs_lat_d; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 20'd0;
      data_q   <= 8'h00;
      rs_lat_q <= 1'b0;
      nib_q    <= 1'b0;
      rs_q     <= 1'b0;
      e_q      <= 1'b0;
      d_q      <= 4'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rs_lat_q <= rs_lat_d;
      nib_q    <= nib_d;
      rs_q     <= rs_d;
      e_q      <= e_d;
      d_q      <= d_d;
      done_q   <= done_d;
    end
  end

  assign rs   = rs_q;
  assign e    = e_q;
  assign d    = d_q;
  assign done = done_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Self-checking bench for lcd_nibble_writer: per-cycle pin waveform compared to an
// arithmetic model of the nibble/wait timeline.
module tb_lcd_nibble_writer;

  localparam int S  = 2;
  localparam int P  = 3;
  localparam int H  = 1;
  localparam int W  = 4;
  localparam int LW = 10;

  logic       clock, reset, in_valid, in_ready, in_rs, in_nibble_only;
  logic [7:0] in_data;
  logic       rs, e, done;
  logic [7:4] d;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] pulses[$];

  lcd_nibble_writer #(
    .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H),
    .WAIT_CYCLES(W), .LONG_WAIT_CYCLES(LW)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rs(in_rs), .in_nibble_only(in_nibble_only),
    .rs(rs), .e(e), .d(d), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Called at a negedge with the block idle; returns at the negedge where ready returns.
  task automatic run_byte(input logic [7:0] data, input logic r, input logic nib,
                          input bit keep_valid);
    int L, T, phases, wt, p, o;
    logic ee, prev_e;
    logic [3:0] dd;
    logic [7:0] exp_v, got_v;
    L      = S + P + H;
    phases = nib ? 1 : 2;
    wt     = (!r && !nib && (data >= 8'h01) && (data <= 8'h03)) ? LW : W;
    T      = phases * L + wt;
    prev_e = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL pre_accept_ready data=%h got=%b want=1", data, in_ready);
    end
    in_valid = 1'b1; in_data = data; in_rs = r; in_nibble_only = nib;
    @(posedge clock);
    @(negedge clock);
    for (int j = 0; j <= T; j++) begin
      if (j < phases * L) begin
        p  = j / L;
        o  = j % L;
        ee = (o >= S) && (o < S + P);
        dd = (p == 0) ? data[7:4] : data[3:0];
      end else begin
        ee = 1'b0;
        dd = (phases == 1) ? data[7:4] : data[3:0];
      end
      exp_v = {(j == T), (j == T), ee, r, dd};
      got_v = {in_ready, done, e, rs, d};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL wave data=%h rs=%b nib=%b cyc=%0d {rdy,done,e,rs,d} got=%b want=%b",
                 data, r, nib, j, got_v, exp_v);
      end
      if (e === 1'b1 && prev_e !== 1'b1) pulses.push_back(d);
      prev_e = e;
      if (j < T) begin
        in_data = 8'($urandom); in_rs = 1'($urandom); in_nibble_only = 1'($urandom);
        if (!keep_valid) in_valid = 1'($urandom);
        @(negedge clock);
      end else if (!keep_valid) begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({in_ready, done, e} !== 3'b100) begin
        n_err++;
        $display("FAIL idle {rdy,done,e} got=%b want=100", {in_ready, done, e});
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock); @(negedge clock);
    n_cmp++;
    if ({in_ready, done, e, rs, d} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_hold got=%b want=00000000", {in_ready, done, e, rs, d});
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, done} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release {rdy,done} got=%b want=10", {in_ready, done});
    end
    @(negedge clock);
    run_byte(8'hFF, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, done, e, rs, d} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_async got=%b want=00000000", {in_ready, done, e, rs, d});
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_rerelease rdy got=%b want=1", in_ready);
    end
    @(negedge clock);
  endtask

  task automatic test_data_byte();
    run_byte(8'h4A, 1'b1, 1'b0, 1'b0);
    idle_check(2);
  endtask

  task automatic test_long_cmd();
    run_byte(8'h01, 1'b0, 1'b0, 1'b0);
    idle_check(1);
    run_byte(8'h80, 1'b0, 1'b0, 1'b0);
    idle_check(1);
    run_byte(8'h02, 1'b0, 1'b0, 1'b0);
    run_byte(8'h03, 1'b0, 1'b0, 1'b0);
    run_byte(8'h04, 1'b0, 1'b0, 1'b0);
    run_byte(8'h01, 1'b1, 1'b0, 1'b0);
    run_byte(8'h00, 1'b0, 1'b0, 1'b0);
    idle_check(1);
  endtask

  task automatic test_nibble_only();
    pulses.delete();
    run_byte(8'h30, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (pulses.size() != 1) begin
      n_err++;
      $display("FAIL nibble_pulse_count got=%0d want=1", pulses.size());
    end
    run_byte(8'h01, 1'b0, 1'b1, 1'b0);
    idle_check(1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] want[4];
    want[0] = 4'h4; want[1] = 4'h1; want[2] = 4'h4; want[3] = 4'h2;
    pulses.delete();
    run_byte(8'h41, 1'b1, 1'b0, 1'b1);
    run_byte(8'h42, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (pulses.size() != 4) begin
      n_err++;
      $display("FAIL b2b_pulse_count got=%0d want=4", pulses.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (pulses[i] !== want[i]) begin
          n_err++;
          $display("FAIL b2b_pulse_d idx=%0d got=%h want=%h", i, pulses[i], want[i]);
        end
      end
    end
    idle_check(1);
  endtask

  task automatic test_reset_mid_pulse();
    int target;
    target = (S + P + H) + S + 1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre_ready got=%b want=1", in_ready);
    end
    in_valid = 1'b1; in_data = 8'h9C; in_rs = 1'b1; in_nibble_only = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    for (int j = 0; j < target; j++) @(negedge clock);
    n_cmp++;
    if ({e, d} !== 5'b1_1100) begin
      n_err++;
      $display("FAIL midrst_in_pulse {e,d} got=%b want=11100", {e, d});
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, done, e, rs, d} !== 8'h00) begin
      n_err++;
      $display("FAIL midrst_async got=%b want=00000000", {in_ready, done, e, rs, d});
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, done, e} !== 3'b100) begin
      n_err++;
      $display("FAIL midrst_release {rdy,done,e} got=%b want=100", {in_ready, done, e});
    end
    idle_check(20);
    run_byte(8'h55, 1'b1, 1'b0, 1'b0);
    idle_check(1);
  endtask

  task automatic test_random();
    logic [7:0] dat;
    logic r, nib;
    bit kv;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(3) == 0) begin
        dat = 8'($urandom_range(3, 1)); r = 1'b0; nib = 1'b0;
      end else begin
        dat = 8'($urandom); r = 1'($urandom); nib = ($urandom_range(3) == 0);
      end
      kv = ($urandom_range(1) == 0);
      run_byte(dat, r, nib, kv);
      if (!kv) idle_check($urandom_range(3, 1));
    end
    in_valid = 1'b0;
    idle_check(1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_rs = 1'b0; in_nibble_only = 1'b0;
    test_reset();
    test_data_byte();
    test_long_cmd();
    test_nibble_only();
    test_back_to_back();
    test_reset_mid_pulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
